// File: rtl/fx_meas_pkg.sv
// fx_meas_pkg: shared FSM state encoding and default widths for the fx period meter.
package fx_meas_pkg;
  localparam int CNT_W_DEF       = 32;
  localparam int NCYC_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } fx_state_e;
endpackage

// File: rtl/fx_edge_sync.sv
// fx_edge_sync: SYNC_STAGES-flop synchroniser plus rising-edge detector.
// Ports: clk, reset (sync, active-high), sig_in (async) -> sig_synced, rise (1-cycle pulse).
module fx_edge_sync
  import fx_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_synced,
  output logic rise
);
  logic [SYNC_STAGES:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[SYNC_STAGES-1:0], sig_in};
  always_ff @(posedge clk) sh_q <= reset ? '0 : sh_d;
  // the extra top flop holds the previous synced value for edge detection
  assign sig_synced = sh_q[SYNC_STAGES-1];
  assign rise       = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
endmodule

// File: rtl/fx_period_meter.sv
// fx_period_meter: reciprocal period meter counting clk cycles across n_cycles periods of sig_fx.
// Ports: clk, reset (sync, active-high), sig_fx (async), start/continuous/n_cycles/timeout (sampled
// on start) -> busy, data_out, data_valid, overflow, timeout_err.
// Build option FX_PERIOD_METER_HIGH_TIME_EN adds high_out (synced-high cycles per measurement).
module fx_period_meter
  import fx_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int NCYC_W      = NCYC_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sig_fx,
  input  logic              start,
  input  logic              continuous,
  input  logic [NCYC_W-1:0] n_cycles,
  input  logic [CNT_W-1:0]  timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  data_out,
  output logic              data_valid,
  output logic              overflow,
  output logic              timeout_err
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0]  high_out
`endif
);
  localparam logic [CNT_W-1:0] MAX = '1;
  fx_state_e state_q, state_d;
  logic [NCYC_W-1:0] n_q, n_d, edges_q, edges_d;
  logic [CNT_W-1:0] to_q, to_d, cnt_q, cnt_d, wd_q, wd_d, data_out_q, data_out_d;
  logic cont_q, cont_d, busy_q, busy_d, data_valid_q, data_valid_d;
  logic overflow_q, overflow_d, timeout_err_q, timeout_err_d;
  logic edge_p, closing, expire;
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
  logic synced;
`else
  logic unused_synced;
`endif
  fx_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_fx),
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
    .sig_synced(synced),
`else
    .sig_synced(unused_synced),
`endif
    .rise      (edge_p)
  );
  always_comb begin
    closing       = state_q == COUNT && edge_p && edges_q == n_q - NCYC_W'(1);
    // an edge in the same cycle as the limit wins over the timeout
    expire        = to_q != '0 && wd_q + CNT_W'(1) == to_q && !edge_p;
    state_d       = state_q;
    n_d           = n_q;
    to_d          = to_q;
    cont_d        = cont_q;
    cnt_d         = cnt_q;
    edges_d       = edges_q;
    wd_d          = wd_q;
    data_out_d    = data_out_q;
    overflow_d    = overflow_q;
    data_valid_d  = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        n_d     = n_cycles == '0 ? NCYC_W'(1) : n_cycles;
        to_d    = timeout;
        cont_d  = continuous;
        wd_d    = '0;
        state_d = ARM;
      end
      ARM: begin
        wd_d = edge_p ? '0 : wd_q + CNT_W'(1);
        if (edge_p) begin
          cnt_d   = '0;
          edges_d = '0;
          state_d = COUNT;
        end else if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      COUNT: begin
        cnt_d   = cnt_q == MAX ? MAX : cnt_q + CNT_W'(1);
        wd_d    = edge_p ? '0 : wd_q + CNT_W'(1);
        edges_d = edge_p ? edges_q + NCYC_W'(1) : edges_q;
        if (closing) begin
          data_out_d   = cnt_d;
          overflow_d   = cnt_q == MAX;
          data_valid_d = 1'b1;
          state_d      = DONE;
        end else if (expire) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        // the DONE cycle already belongs to the next period in continuous mode
        cnt_d   = CNT_W'(1);
        edges_d = '0;
        state_d = cont_q ? COUNT : IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      n_q           <= '0;
      to_q          <= '0;
      cont_q        <= 1'b0;
      cnt_q         <= '0;
      edges_q       <= '0;
      wd_q          <= '0;
      data_out_q    <= '0;
      overflow_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      to_q          <= to_d;
      cont_q        <= cont_d;
      cnt_q         <= cnt_d;
      edges_q       <= edges_d;
      wd_q          <= wd_d;
      data_out_q    <= data_out_d;
      overflow_q    <= overflow_d;
      data_valid_q  <= data_valid_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end
  assign busy        = busy_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hi_q, hi_d, hi_inc, high_out_q, high_out_d;
  always_comb begin
    hi_inc     = synced && hi_q != MAX ? hi_q + CNT_W'(1) : hi_q;
    // window matches cnt: opening edge excluded, closing edge and DONE cycle included
    hi_d       = state_q == ARM ? '0 : state_q == DONE ? CNT_W'(synced) : state_q == COUNT ? hi_inc : hi_q;
    high_out_d = closing ? hi_inc : high_out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= '0;
      high_out_q <= '0;
    end else begin
      hi_q       <= hi_d;
      high_out_q <= high_out_d;
    end
  end
  assign high_out = high_out_q;
`endif
endmodule

// File: tb/tb_fx_period_meter.sv
// tb_fx_period_meter: randomized scoreboard bench for fx_period_meter (32-bit and 8-bit instances).
module tb_fx_period_meter;
  typedef struct {
    bit          is_to;
    logic [31:0] data;
    bit          ovf;
    logic [31:0] hi;
    int          gap;
    int          at;
  } exp_t;
  logic clk, reset, sig_fx, start, continuous;
  logic [15:0] n_cycles;
  logic [31:0] timeout, data_out;
  logic busy, data_valid, overflow, timeout_err;
  logic sig8, start8, busy8, v8, o8, to8;
  logic [7:0] d8;
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
  logic [31:0] high_out;
  logic [7:0] high8;
`endif
  int compared = 0, mismatched = 0, cyc = 0, last_valid = 0, start_cyc = 0;
  int gen_p = 20, gen_h = 5;
  bit gen_en = 0;
  exp_t q[$], q8[$];

  fx_period_meter dut (
    .clk(clk), .reset(reset), .sig_fx(sig_fx), .start(start), .continuous(continuous),
    .n_cycles(n_cycles), .timeout(timeout), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .overflow(overflow), .timeout_err(timeout_err)
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
    , .high_out(high_out)
`endif
  );
  fx_period_meter #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .sig_fx(sig8), .start(start8), .continuous(1'b0),
    .n_cycles(16'd1), .timeout(8'd0), .busy(busy8), .data_out(d8),
    .data_valid(v8), .overflow(o8), .timeout_err(to8)
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
    , .high_out(high8)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // square-wave sources: sig_fx is programmable, sig8 is a fixed 300-cycle 50% wave
  initial begin
    sig_fx = 0;
    forever begin
      if (gen_en) begin
        sig_fx = 1;
        repeat (gen_h) @(negedge clk);
        sig_fx = 0;
        repeat (gen_p - gen_h) @(negedge clk);
      end else begin
        sig_fx = 0;
        @(negedge clk);
      end
    end
  end
  initial begin
    sig8 = 0;
    forever begin
      repeat (150) @(negedge clk);
      sig8 = ~sig8;
    end
  end

  // monitor: pops the expected result whenever the DUT presents one
  always @(negedge clk) begin
    exp_t e;
    if (!reset && data_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("kind_valid", e.is_to, 0);
        chk("data_out", data_out, e.data);
        chk("overflow", overflow, e.ovf);
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
        chk("high_out", high_out, e.hi);
`endif
        if (e.gap != 0) chk("valid_gap", cyc - last_valid, e.gap);
      end
      last_valid = cyc;
    end
    if (!reset && timeout_err) begin
      if (q.size() == 0) chk("unexpected_timeout", 1, 0);
      else begin
        e = q.pop_front();
        chk("kind_timeout", e.is_to, 1);
        chk("timeout_cycle", cyc, e.at);
      end
    end
    if (!reset && v8) begin
      if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("data_out8", d8, e.data);
        chk("overflow8", o8, e.ovf);
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
        chk("high_out8", high8, e.hi);
`endif
      end
    end
  end

  task automatic set_gen(input int p, input int h);
    gen_en = 0;
    repeat (50) @(negedge clk);
    gen_p = p;
    gen_h = h;
    gen_en = 1;
  endtask

  task automatic do_start(input int n, input int to, input bit cont);
    @(negedge clk);
    start = 1;
    n_cycles = 16'(n);
    timeout = 32'(to);
    continuous = cont;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push(input int data, input bit ovf, input int hi, input int gap);
    exp_t e;
    e.is_to = 0; e.data = 32'(data); e.ovf = ovf; e.hi = 32'(hi); e.gap = gap; e.at = 0;
    q.push_back(e);
  endtask

  task automatic wait_done(input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    if (i == limit) begin
      chk({name, "_bound"}, 0, 1);
      q.delete();
    end
  endtask

  task automatic measure(input int p, input int h, input int n, input int to);
    int ne;
    ne = n == 0 ? 1 : n;
    set_gen(p, h);
    push(p * ne, 0, h * ne, 0);
    do_start(n, to, 0);
    wait_done(p * (ne + 3) + 200, "measure");
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
`ifdef FX_PERIOD_METER_HIGH_TIME_EN
    chk({tag, "_high_out"}, high_out, 0);
`endif
  endtask

  initial begin
    exp_t e;
    int p, h, n, i;
    reset = 1; start = 0; continuous = 0; n_cycles = 0; timeout = 0; start8 = 0;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    reset = 0;
    measure(20, 5, 10, 0);
    measure(20, 5, 0, 0);
    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(40, 3);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(6, 0);
      measure(p, h, n, $urandom_range(1, 0) ? p * 3 + 20 : 0);
    end
    gen_en = 0;
    repeat (50) @(negedge clk);
    e.is_to = 1; e.data = 0; e.ovf = 0; e.hi = 0; e.gap = 0;
    do_start(1, 100, 0);
    e.at = start_cyc + 100;
    q.push_back(e);
    wait_done(300, "timeout");
    chk("busy_after_timeout", busy, 0);
    set_gen(20, 5);
    for (int k = 0; k < 5; k++) push(80, 0, 20, k == 0 ? 0 : 80);
    do_start(4, 0, 1);
    for (i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
    if (i == 1000) begin
      chk("continuous_bound", 0, 1);
      q.delete();
    end
    chk("busy_continuous", busy, 1);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    do_start(50, 0, 0);
    repeat (100) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_idle_outputs("midreset");
    push(40, 0, 10, 0);
    do_start(2, 0, 0);
    repeat (10) @(negedge clk);
    do_start(7, 0, 1);
    wait_done(400, "after_reset");
    repeat (200) @(negedge clk);
    chk("busy_final", busy, 0);
    e.is_to = 0; e.data = 255; e.ovf = 1; e.hi = 150; e.gap = 0; e.at = 0;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (i = 0; i < 2000 && (q8.size() != 0 || busy8); i++) @(negedge clk);
    if (i == 2000) chk("overflow_bound", 0, 1);
    chk("timeout_err8", to8, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fx_period_meter.md
Name: fx_period_meter

Overview:
Reciprocal period/frequency meter for asynchronous square-wave sources such as the NE555 output. It counts `clk` cycles across a runtime-programmable number of `sig_fx` periods. Over the fixed-N period counter it adds single-shot and continuous modes, a timeout, saturation/overflow flagging and a start/busy handshake. It sits between the pin-level oscillator input and the measurement/display datapath.

Parameters:
- CNT_W, 32, width of the clk-cycle counter and of `data_out`.
- NCYC_W, 16, width of the programmable period count `n_cycles`.
- SYNC_STAGES, 2, number of synchroniser flops on `sig_fx` (legal values ≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sig_fx  in  1  asynchronous measured signal.
- start  in  1  one-cycle request to begin a measurement.
- continuous  in  1  1 = re-arm automatically after each result; sampled on start.
- n_cycles  in  NCYC_W  number of sig_fx periods to span; sampled on start.
- timeout  in  CNT_W  abort limit in clk cycles; 0 = disabled; sampled on start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- data_out  out  CNT_W  clk cycles between the opening edge and the closing edge.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- overflow  out  1  qualifies data_out; 1 = counter saturated.
- timeout_err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset: all outputs are 0; state goes to IDLE; the counter and the latched configuration are cleared. Reset asserted mid-measurement aborts it with no data_valid or timeout_err pulse.
- Input path: sig_fx passes through SYNC_STAGES flops and then a rising-edge detector. A sig_fx rise reaches the `edge` pulse SYNC_STAGES+1 clk cycles later.
- States: IDLE, ARM, COUNT, DONE.
- IDLE, start=1: latch n_cycles (0 is treated as 1), timeout and continuous; go to ARM. start is ignored in any state other than IDLE.
- ARM: wait for an edge. On the edge, set cnt=0 and edges=0, then go to COUNT.
- COUNT: cnt increments every cycle and saturates at 2^CNT_W-1, setting an internal sat flag. Each edge increments `edges`.
- COUNT, closing edge: the edge arriving when edges == n_cycles-1 is the closing edge. On it, the result register takes cnt+1 (saturating) and the state goes to DONE. The result equals the cycle distance between the opening and closing edge pulses.
- DONE (one cycle): data_valid=1; data_out and overflow are updated. Both are held until the next data_valid.
- DONE, continuous=1: go directly to COUNT with cnt=1 and edges=0. The closing edge becomes the next opening edge, so no period is lost, and busy stays 1.
- DONE, continuous=0: go to IDLE; busy drops in the following cycle.
- Timeout: a separate watchdog counter runs in ARM and COUNT and is cleared on every edge. If it reaches the latched timeout value (nonzero), timeout_err pulses for one cycle and the state goes to IDLE. No data_valid is produced and data_out is unchanged.
- Continuous mode stops only on reset or timeout. A start pulse is ignored while busy.
- Simultaneous events: an edge and the timeout limit in the same cycle resolve in favour of the edge.

Optional Feature:
- Macro: FX_PERIOD_METER_HIGH_TIME_EN.
- Defined: adds output port `high_out` [CNT_W]. It counts the clk cycles in COUNT with synced sig_fx=1 (saturating) and is updated with data_valid, which enables duty-cycle computation.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `fx_meas_pkg`: the state encodings (IDLE/ARM/COUNT/DONE localparams) and the default widths.
- One sub-module, `fx_edge_sync`: the parametrised SYNC_STAGES synchroniser plus rising-edge detector. It outputs `sig_synced` and `rise`, uses synchronous reset, and resets its flops to 0.

Test Plan:
- Single-shot: sig_fx period 20 clk, n_cycles=10, continuous=0 → one data_valid, data_out=200, overflow=0, busy then drops to 0.
- n_cycles=0 with period 20 → treated as 1, data_out=20.
- Timeout: timeout=100, sig_fx held low → timeout_err pulses exactly once, 100 cycles after entering ARM. No data_valid; state returns to IDLE.
- Continuous: period 20, n_cycles=4 → data_valid every 80 clk with data_out=80 each time, and no gaps or missed periods over 5 results.
- Overflow: CNT_W=8, period 300, n_cycles=1 → data_out=255, overflow=1.
- Reset mid-COUNT, then start ignored while busy → all outputs 0 after reset. A later start measures correctly (period 20, n=2 → 40). With FX_PERIOD_METER_HIGH_TIME_EN and 25% duty, high_out=10.
